// File: rtl/dma_mem_pkg.sv
// Shared types for the DMA memory-side responder.
//   dma_cmd_t     : one queued bus command {we, addr, wdata}
//   resp_state_e  : responder FSM states
//   BAD_READ_DATA : data returned for a read of an illegal address
// The command struct is sized by DMA_ADDR_WIDTH/DMA_DATA_WIDTH; the
// responder's ADDR_WIDTH/DATA_WIDTH parameters must match them.
package dma_mem_pkg;

    localparam int DMA_ADDR_WIDTH = 32;
    localparam int DMA_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      we;
        logic [DMA_ADDR_WIDTH-1:0] addr;
        logic [DMA_DATA_WIDTH-1:0] wdata;
    } dma_cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } resp_state_e;

    localparam logic [DMA_DATA_WIDTH-1:0] BAD_READ_DATA = '0;

endpackage

// File: rtl/dma_cmd_fifo.sv
// Synchronous command FIFO.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i at the tail (ignored when full and not popping)
//   pop_i     : drop the head entry (ignored when empty)
//   rdata_o   : head entry, valid while empty_o is low
//   full_o, empty_o, count_o : occupancy
// DEPTH must be a power of two so the pointers wrap naturally.
module dma_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed only when the head leaves the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // NOTE: storage arrays carry no reset; the pointers alone define which
    // entries are live, and leaving the array unreset keeps it in RAM cells.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_mem_resp.sv
// Memory-side responder for the DMA bus.
//   clk, rst        : clock, synchronous active-high reset
//   data_req_i      : one-word read request
//   write_req_i     : one-word write request
//   addr_i          : byte address of the request
//   write_data_i    : write data, sampled with write_req_i
//   nib_hold_req_o  : backpressure; requests are ignored while high
//   read_data_o     : read data, held until the next response
//   read_valid_o    : one-cycle pulse, read_data_o valid
//   err_o           : one-cycle pulse, bad address or conflicting request
//   busy_o          : command queued or FSM active
// Accepted requests are queued and served in order against a word-addressed
// SRAM with RD_LATENCY cycles from access to read data.
module dma_mem_resp
    import dma_mem_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter int unsigned          MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int unsigned          RD_LATENCY = 2,
    parameter int unsigned          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_req_i,
    input  logic                  write_req_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic                  nib_hold_req_o,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  read_valid_o,
    output logic                  err_o,
    output logic                  busy_o
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    // ---------------------------------------------------------------- queue
    dma_cmd_t         push_cmd, head;
    logic             accept, pop;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count, count_d;

    resp_state_e      state_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic             hold_q;
    logic             conflict_q;
    logic             rd_bad_q;
    logic [DATA_WIDTH-1:0] read_data_q;

    assign accept   = (data_req_i ^ write_req_i) && !hold_q && !fifo_full;
    assign push_cmd = '{we: write_req_i, addr: addr_i, wdata: write_data_i};
    // ACCESS always serves (and retires) the head entry.
    assign pop      = (state_q == ACCESS);
    // Occupancy after this edge: drives both backpressure and the FSM, so a
    // command pushed this cycle is seen without an extra idle cycle.
    assign count_d  = fifo_count + CNT_W'(accept) - CNT_W'(pop);

    dma_cmd_fifo #(
        .WIDTH ($bits(dma_cmd_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .wdata_i (push_cmd),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // --------------------------------------------------------- address decode
    logic [ADDR_WIDTH-1:0] head_word;
    logic [IDX_W-1:0]      head_idx;
    logic                  head_bad;

    assign head_word = (head.addr - BASE_ADDR) >> 2;
    assign head_idx  = head_word[IDX_W-1:0];
    assign head_bad  = (head.addr[1:0] != 2'b00) || (head.addr < BASE_ADDR) ||
                       (head_word >= ADDR_WIDTH'(MEM_DEPTH));

    // ------------------------------------------------------------------ SRAM
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] sram_q;
    logic                  sram_we, sram_re;

    assign sram_we = !rst && (state_q == ACCESS) &&  head.we && !head_bad;
    assign sram_re = !rst && (state_q == ACCESS) && !head.we && !head_bad;

    // sram_q is only reloaded in ACCESS, so it stays stable through WAIT/RESP.
    always_ff @(posedge clk) begin
        if (sram_we) mem_q[head_idx] <= head.wdata;
        if (sram_re) sram_q <= mem_q[head_idx];
    end

    // ------------------------------------------------------------------- FSM
    logic [DATA_WIDTH-1:0] resp_data;

    assign resp_data = rd_bad_q ? BAD_READ_DATA : sram_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lat_cnt_q   <= '0;
            hold_q      <= 1'b0;
            conflict_q  <= 1'b0;
            rd_bad_q    <= 1'b0;
            read_data_q <= '0;
        end else begin
            hold_q     <= (count_d >= CNT_W'(FIFO_DEPTH - 1));
            conflict_q <= data_req_i && write_req_i && !hold_q;

            case (state_q)
                IDLE: begin
                    if (count_d != '0) state_q <= ACCESS;
                end
                ACCESS: begin
                    if (head.we) begin
                        state_q <= (count_d != '0) ? ACCESS : IDLE;
                    end else begin
                        rd_bad_q <= head_bad;
                        if (RD_LATENCY == 1) begin
                            state_q <= RESP;
                        end else begin
                            lat_cnt_q <= LAT_W'(RD_LATENCY - 1);
                            state_q   <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    lat_cnt_q <= lat_cnt_q - 1'b1;
                    if (lat_cnt_q == LAT_W'(1)) state_q <= RESP;
                end
                RESP: begin
                    read_data_q <= resp_data;
                    state_q     <= (count_d != '0) ? ACCESS : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // --------------------------------------------------------------- outputs
    // All terms decode flops; the write error must land in the ACCESS cycle.
    assign nib_hold_req_o = hold_q;
    assign read_valid_o   = (state_q == RESP);
    assign read_data_o    = (state_q == RESP) ? resp_data : read_data_q;
    assign err_o          = conflict_q ||
                            ((state_q == ACCESS) && head.we && head_bad) ||
                            ((state_q == RESP) && rd_bad_q);
    assign busy_o         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_dma_mem_resp.sv
// Directed self-checking bench for dma_mem_resp at default parameters.
module tb_dma_mem_resp;

    localparam int RD_LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req_i, write_req_i;
    logic [31:0] addr_i, write_data_i;
    logic        nib_hold_req_o, read_valid_o, err_o, busy_o;
    logic [31:0] read_data_o;

    always #5 clk = ~clk;

    dma_mem_resp #(.RD_LATENCY(RD_LATENCY)) dut (
        .clk            (clk),
        .rst            (rst),
        .data_req_i     (data_req_i),
        .write_req_i    (write_req_i),
        .addr_i         (addr_i),
        .write_data_i   (write_data_i),
        .nib_hold_req_o (nib_hold_req_o),
        .read_data_o    (read_data_o),
        .read_valid_o   (read_valid_o),
        .err_o          (err_o),
        .busy_o         (busy_o)
    );

    // cyc = number of rising edges so far; at the falling edge of the cycle
    // that ends at edge K it reads K-1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] resp_data_q [$];
    bit          resp_err_q  [$];
    int          resp_cyc_q  [$];
    int          err_cyc_q   [$];
    int          hold_cnt = 0;

    always @(negedge clk) begin
        if (read_valid_o) begin
            resp_data_q.push_back(read_data_o);
            resp_err_q.push_back(err_o);
            resp_cyc_q.push_back(cyc);
        end
        if (err_o) err_cyc_q.push_back(cyc);
        if (nib_hold_req_o) hold_cnt++;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: observed %h, expected %h", tag, got, exp);
    endtask

    // Present one request until accepted; acc = cyc just after the accepting edge.
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         output int acc);
        bit held;
        acc          = -1;
        data_req_i   = ~we;
        write_req_i  = we;
        addr_i       = addr;
        write_data_i = wd;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            held = nib_hold_req_o;
            @(posedge clk);
            #1;
            if (!held) begin
                acc = cyc;
                break;
            end
        end
        data_req_i  = 1'b0;
        write_req_i = 1'b0;
        if (acc < 0) check("accept_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        bool_loop: for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (!busy_o) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        check("idle_timeout", 1, 0);
    endtask

    task automatic check_resp(input string tag, input int idx, input logic [31:0] exp_data,
                              input bit exp_err);
        if (idx >= resp_data_q.size()) begin
            check({tag, "_missing"}, 0, 1);
        end else begin
            check({tag, "_data"}, resp_data_q[idx], exp_data);
            check({tag, "_err"}, 32'(resp_err_q[idx]), 32'(exp_err));
        end
    endtask

    int acc, acc2, m, e, h, ce;

    initial begin
        rst = 1'b1;
        data_req_i = 1'b0; write_req_i = 1'b0; addr_i = '0; write_data_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", 32'(read_valid_o), 0);
        check("rst_err",   32'(err_o), 0);
        check("rst_hold",  32'(nib_hold_req_o), 0);
        check("rst_busy",  32'(busy_o), 0);
        check("rst_data",  read_data_o, 0);
        @(posedge clk); #1;

        // Basic read of a preloaded word: response 2 cycles after the accept edge
        issue(1'b1, 32'h14, 32'hA5A5_0005, acc);
        wait_idle();
        m = resp_data_q.size(); e = err_cyc_q.size();
        @(posedge clk); #1;
        issue(1'b0, 32'h14, 32'h0, acc);
        wait_idle();
        check("rd1_count", resp_data_q.size() - m, 1);
        check_resp("rd1", m, 32'hA5A5_0005, 1'b0);
        if (m < resp_cyc_q.size()) check("rd1_latency", resp_cyc_q[m], acc + RD_LATENCY);
        check("rd1_no_err", err_cyc_q.size() - e, 0);

        // Write then read same address in the next cycle
        m = resp_data_q.size(); h = hold_cnt;
        @(posedge clk); #1;
        issue(1'b1, 32'h40, 32'h1234_5678, acc);
        issue(1'b0, 32'h40, 32'h0, acc2);
        wait_idle();
        check("raw_b2b", acc2 - acc, 1);
        check_resp("raw", m, 32'h1234_5678, 1'b0);
        check("raw_no_hold", hold_cnt - h, 0);

        // Backpressure: preload 19 words, then 19 back-to-back reads
        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) issue(1'b1, 32'h100 + 32'(4 * i), 32'h5100_0000 + 32'(i), acc);
        wait_idle();
        m = resp_data_q.size(); h = hold_cnt; e = err_cyc_q.size();
        @(posedge clk); #1;
        for (int i = 0; i < 19; i++) issue(1'b0, 32'h100 + 32'(4 * i), 32'h0, acc);
        wait_idle();
        check("bp_hold_seen", 32'(hold_cnt > h), 1);
        check("bp_count", resp_data_q.size() - m, 19);
        for (int i = 0; i < 19; i++)
            if (m + i < resp_data_q.size())
                check($sformatf("bp_word%0d", i), resp_data_q[m + i], 32'h5100_0000 + 32'(i));
        check("bp_no_err", err_cyc_q.size() - e, 0);

        // Bad addresses
        @(posedge clk); #1;
        issue(1'b1, 32'h0, 32'hCAFE_0000, acc);
        wait_idle();
        m = resp_data_q.size(); e = err_cyc_q.size();
        @(posedge clk); #1;
        issue(1'b1, 32'h1000, 32'hDEAD_BEEF, acc);
        wait_idle();
        check("badwr_err_count", err_cyc_q.size() - e, 1);
        if (e < err_cyc_q.size()) check("badwr_err_cycle", err_cyc_q[e], acc);
        check("badwr_no_resp", resp_data_q.size() - m, 0);
        e = err_cyc_q.size();
        @(posedge clk); #1;
        issue(1'b0, 32'h1002, 32'h0, acc);
        issue(1'b0, 32'h1000, 32'h0, acc);
        issue(1'b0, 32'h0, 32'h0, acc);
        wait_idle();
        check("bad_resp_count", resp_data_q.size() - m, 3);
        check_resp("bad_misalign", m, 32'h0, 1'b1);
        check_resp("bad_range", m + 1, 32'h0, 1'b1);
        check_resp("word0_intact", m + 2, 32'hCAFE_0000, 1'b0);
        check("bad_rd_err_count", err_cyc_q.size() - e, 2);

        // Conflicting request: err next cycle, nothing accepted
        @(posedge clk); #1;
        issue(1'b1, 32'h20, 32'h0808_0808, acc);
        wait_idle();
        m = resp_data_q.size(); e = err_cyc_q.size();
        @(posedge clk); #1;
        data_req_i = 1'b1; write_req_i = 1'b1; addr_i = 32'h20; write_data_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        ce = cyc;
        data_req_i = 1'b0; write_req_i = 1'b0;
        repeat (5) @(negedge clk);
        check("conf_err_count", err_cyc_q.size() - e, 1);
        if (e < err_cyc_q.size()) check("conf_err_cycle", err_cyc_q[e], ce);
        check("conf_no_resp", resp_data_q.size() - m, 0);
        @(posedge clk); #1;
        issue(1'b0, 32'h20, 32'h0, acc);
        wait_idle();
        check_resp("conf_word8", m, 32'h0808_0808, 1'b0);

        // Reset during WAIT discards the pending read
        m = resp_data_q.size();
        @(posedge clk); #1;
        issue(1'b0, 32'h14, 32'h0, acc);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 32'(read_valid_o), 0);
        check("mid_rst_err",   32'(err_o), 0);
        check("mid_rst_hold",  32'(nib_hold_req_o), 0);
        check("mid_rst_busy",  32'(busy_o), 0);
        check("mid_rst_data",  read_data_o, 0);
        repeat (10) @(negedge clk);
        check("mid_rst_dropped", resp_data_q.size() - m, 0);
        @(posedge clk); #1;
        issue(1'b0, 32'h14, 32'h0, acc);
        wait_idle();
        check_resp("post_rst", m, 32'hA5A5_0005, 1'b0);
        if (m < resp_cyc_q.size()) check("post_rst_latency", resp_cyc_q[m], acc + RD_LATENCY);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dma_mem_resp.md
Name: dma_mem_resp

Overview:
Memory-side responder for the DMA bus interface. It accepts word read and write requests from the DMA master and queues them in a small command FIFO. Commands are served against an internal word-addressed SRAM model with configurable read latency. The block drives nib_hold_req_o as backpressure when the queue nears full. It serves as the external-memory endpoint in the sparse-matrix/VRF load path and as the bench memory for DMA verification.

Parameters:
DATA_WIDTH, 32, bus data width in bits
ADDR_WIDTH, 32, byte address width
MEM_DEPTH, 1024, SRAM depth in DATA_WIDTH words
BASE_ADDR, 32'h0000_0000, byte address of word 0
RD_LATENCY, 2, cycles from SRAM access to read data valid (≥1)
FIFO_DEPTH, 4, command FIFO entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
data_req_i  in  1  read request, one word
write_req_i  in  1  write request, one word
addr_i  in  ADDR_WIDTH  byte address of the request
write_data_i  in  DATA_WIDTH  write data, sampled with write_req_i
nib_hold_req_o  out  1  backpressure; requests ignored while high
read_data_o  out  DATA_WIDTH  read data
read_valid_o  out  1  one-cycle pulse; read_data_o valid
err_o  out  1  one-cycle pulse; bad address or conflicting request
busy_o  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst high at an edge): FIFO emptied, FSM→IDLE, all outputs 0. SRAM contents are not reset. If rst asserts mid-read, the pending response is discarded and read_valid_o never fires for it.
- Accept: in cycle N, if exactly one of data_req_i/write_req_i is high and nib_hold_req_o is low, push {we, addr, wdata} at edge N.
- Both requests high: neither is accepted; err_o pulses in cycle N+1.
- Requests while nib_hold_req_o is high are ignored; the master must re-present them.
- nib_hold_req_o is registered: it is high in the next cycle when the next FIFO count ≥ FIFO_DEPTH-1. This guarantees no overflow.
- Word index is (addr - BASE_ADDR)>>2. A bad address is addr[1:0]≠0, addr<BASE_ADDR, or index≥MEM_DEPTH.
- FSM states:
  - IDLE: FIFO non-empty → ACCESS (pop head).
  - ACCESS:
    - Write: SRAM written this cycle; bad address drops the write and pulses err_o this cycle. Then → IDLE, or → ACCESS if the FIFO is non-empty (back-to-back writes, 1 per cycle).
    - Read: SRAM read issued; → WAIT with lat_cnt=RD_LATENCY-1, or → RESP directly if RD_LATENCY=1.
  - WAIT: decrement lat_cnt; at 0 → RESP.
  - RESP: read_valid_o=1 with read_data_o=word. A bad read address returns 0 with err_o=1 in the same cycle, so response count always equals accepted read count. Then → ACCESS if FIFO non-empty, else IDLE.
- read_data_o holds its last value until the next RESP.
- Latency: read accepted at edge N with the block idle → read_valid_o in cycle N+1+RD_LATENCY (N+3 at default).
- Read throughput: one per RD_LATENCY+1 cycles.
- Ordering: strictly FIFO. A read after a write to the same address returns the new data.
- Push and pop in the same cycle are allowed; count is unchanged.

Decomposition:
- Package dma_mem_pkg: dma_cmd_t struct {we, addr, wdata}; resp_state_e enum {IDLE, ACCESS, WAIT, RESP}; BAD_READ_DATA = 0.
- Sub-module dma_cmd_fifo: synchronous FIFO with parameters WIDTH/DEPTH. Ports push/pop/full/empty/count; synchronous active-high reset.
- SRAM is an inferred array inside dma_mem_resp.

Test Plan:
- Preload word 5 with 32'hA5A5_0005, idle block. Read addr 32'h14 at cycle 10 → read_valid_o=1 with read_data_o=32'hA5A5_0005 in cycle 13; err_o stays 0.
- Write 32'h1234_5678 to 32'h40, then read 32'h40 in the next cycle → read returns 32'h1234_5678; no hold asserted.
- Present data_req_i continuously for 19 words from 32'h100 (re-presenting when held) → nib_hold_req_o asserts once count reaches 3. Exactly 19 read_valid_o pulses, data in address order, no drops or duplicates.
- Read 32'h1002 (misaligned) and 32'h1000 (index 1024) → each yields read_valid_o with data 0 and err_o=1. A write to 32'h1000 pulses err_o and leaves memory unchanged.
- Assert data_req_i and write_req_i together at 32'h20 → err_o pulses the next cycle; no read_valid_o; word 8 unchanged.
- Accept a read, then raise rst for one cycle during WAIT → no read_valid_o afterwards. All outputs are 0 the cycle after reset, and a new read completes with normal latency.
